// File: rtl/prbs_pattern_tx.sv
// PRBS-7 (x^7+x^6+1) word transmitter with error injection and a delivered-word counter.
// Optional: define PRBS_TX_ERR_CNT_EN to add inj_bit_count (total injected bit flips, saturating).
module prbs_pattern_tx #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [6:0]       seed,
  input  logic             inj_req,
  input  logic [7:0]       inj_mask,
  output logic [7:0]       data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] word_count,
  output logic             busy
`ifdef PRBS_TX_ERR_CNT_EN
  ,
  output logic [15:0]      inj_bit_count
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [6:0]       r_lfsr;
  logic [7:0]       r_data;
  logic [7:0]       r_mask;
  logic             r_valid;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;

  logic [6:0] w_seed_fix;
  logic [6:0] w_src;
  logic [6:0] w_chain [0:8];
  logic [7:0] w_word;
  logic       w_accept;
  logic       w_load;

  // An all-zero seed would lock the LFSR, so it is replaced by all-ones.
  assign w_seed_fix = (seed == 7'd0) ? 7'h7F : seed;
  assign w_src      = (r_state == S_IDLE) ? w_seed_fix : r_lfsr;

  // Eight LFSR steps unrolled; the first generated bit lands in w_word[7].
  assign w_chain[0] = w_src;
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_step
      assign w_word[7-gi]  = w_chain[gi][6] ^ w_chain[gi][5];
      assign w_chain[gi+1] = {w_chain[gi][5:0], w_word[7-gi]};
    end
  endgenerate

  assign w_accept = (r_state == S_RUN) && out_ready;
  assign w_load   = en && ((r_state == S_IDLE) || w_accept);

`ifdef PRBS_TX_ERR_CNT_EN
  logic [15:0] r_inj_cnt;
  logic [3:0]  w_pop;
  logic [16:0] w_inj_sum;

  always_comb begin
    w_pop = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_pop = w_pop + {3'd0, r_mask[i]};
    end
  end

  assign w_inj_sum = {1'b0, r_inj_cnt} + {13'd0, w_pop};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inj_cnt <= 16'd0;
    end else if (w_load && (r_mask != 8'd0)) begin
      r_inj_cnt <= w_inj_sum[16] ? 16'hFFFF : w_inj_sum[15:0];
    end
  end

  assign inj_bit_count = r_inj_cnt;
`endif

  // Pending injection mask: applied and cleared on each load; a same-cycle request targets the next word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mask <= 8'd0;
    end else if (w_load) begin
      r_mask <= inj_req ? inj_mask : 8'd0;
    end else if (inj_req) begin
      r_mask <= r_mask | inj_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= 7'h7F;
      r_data  <= 8'd0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (en) begin
            r_lfsr  <= w_chain[8];
            r_data  <= w_word ^ r_mask;
            r_valid <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (out_ready) begin
            r_count <= r_count + 1'b1;
            if (en) begin
              r_lfsr <= w_chain[8];
              r_data <= w_word ^ r_mask;
            end else begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign out_valid  = r_valid;
  assign busy       = r_busy;
  assign word_count = r_count;

endmodule

// File: tb/tb_prbs_pattern_tx.sv
// Self-checking bench for prbs_pattern_tx: directed steps plus randomized traffic against a bit-stream model.
// Checks inj_bit_count as well when PRBS_TX_ERR_CNT_EN is defined.
`timescale 1ns/1ps
module tb_prbs_pattern_tx;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [6:0]    seed = 7'h7F;
  logic          inj_req = 1'b0;
  logic [7:0]    inj_mask = 8'd0;
  logic [7:0]    data_out;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [CW-1:0] word_count;
  logic          busy;
`ifdef PRBS_TX_ERR_CNT_EN
  logic [15:0]   inj_bit_count;
`endif

  int total = 0;
  int bad = 0;

  // Model state
  logic [7:0] m_data;
  logic       m_valid;
  int         m_count;
  logic [6:0] m_seed;
  int         m_k;
  logic [7:0] m_pend;
  int         m_inj;

  prbs_pattern_tx #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .seed(seed),
    .inj_req(inj_req), .inj_mask(inj_mask),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .word_count(word_count), .busy(busy)
`ifdef PRBS_TX_ERR_CNT_EN
    , .inj_bit_count(inj_bit_count)
`endif
  );

  always #5 clk = ~clk;

  // Word k of the stream: bits b[n] = b[n-7]^b[n-6], history seeded oldest-first from the seed.
  function automatic logic [7:0] ref_word(input logic [6:0] sd, input int k);
    bit b[$];
    logic [6:0] s;
    logic [7:0] w;
    s = (sd == 7'd0) ? 7'h7F : sd;
    for (int i = 6; i >= 0; i--) b.push_back(s[i]);
    for (int n = 0; n < 8 * (k + 1); n++) b.push_back(b[b.size() - 7] ^ b[b.size() - 6]);
    w = 8'd0;
    for (int j = 0; j < 8; j++) w[7 - j] = b[7 + 8 * k + j];
    return w;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    logic load;
    load = 1'b0;
    if (!rst_n) begin
      m_data = 8'd0; m_valid = 1'b0; m_count = 0; m_pend = 8'd0; m_inj = 0; m_k = 0;
    end else begin
      if (!m_valid) begin
        if (en) begin
          m_seed = seed; m_k = 0; load = 1'b1;
        end
      end else if (out_ready) begin
        m_count = (m_count + 1) % (1 << CW);
        if (en) begin
          m_k = m_k + 1; load = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (load) begin
        m_data  = ref_word(m_seed, m_k) ^ m_pend;
        m_inj   = m_inj + $countones(m_pend);
        if (m_inj > 16'hFFFF) m_inj = 16'hFFFF;
        m_pend  = inj_req ? inj_mask : 8'd0;
        m_valid = 1'b1;
      end else if (inj_req) begin
        m_pend = m_pend | inj_mask;
      end
    end
  endtask

  task automatic cyc(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".data"}, {24'd0, data_out}, {24'd0, m_data});
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, m_valid});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, m_valid});
    chk({tag, ".count"}, {28'd0, word_count}, m_count);
`ifdef PRBS_TX_ERR_CNT_EN
    chk({tag, ".injcnt"}, {16'd0, inj_bit_count}, m_inj);
`endif
    $display("cyc %-8s rst_n=%b en=%b rdy=%b inj=%b data=%02h valid=%b count=%0d",
             tag, rst_n, en, out_ready, inj_req, data_out, out_valid, word_count);
  endtask

  initial begin
    m_data = 0; m_valid = 0; m_count = 0; m_seed = 7'h7F; m_k = 0; m_pend = 0; m_inj = 0;

    // Reset state
    rst_n = 1'b0;
    cyc("reset");
    cyc("reset");
    chk("reset.data0", {24'd0, data_out}, 32'h0);

    // Stream from seed 7F, ready always high
    rst_n = 1'b1; en = 1'b1; seed = 7'h7F; out_ready = 1'b1;
    cyc("start");
    chk("first_word", {24'd0, data_out}, 32'h02);
    cyc("run");
    chk("second_word", {24'd0, data_out}, 32'h0C);
    chk("count_1", {28'd0, word_count}, 32'd1);
    repeat (4) cyc("run");

    // Stop, then restart with seed 0 (treated as 7F)
    en = 1'b0;
    cyc("stop");
    cyc("idle");
    seed = 7'h00; en = 1'b1;
    cyc("seed0");
    chk("seed0_word0", {24'd0, data_out}, 32'h02);

    // Backpressure for 5 cycles, injection while word0 is held
    out_ready = 1'b0; inj_req = 1'b1; inj_mask = 8'h81;
    cyc("hold");
    inj_req = 1'b0; inj_mask = 8'h00;
    repeat (4) cyc("hold");
    chk("held_word", {24'd0, data_out}, 32'h02);
    out_ready = 1'b1;
    cyc("inj");
    chk("inj_word1", {24'd0, data_out}, 32'h8D);
    cyc("clean");
`ifdef PRBS_TX_ERR_CNT_EN
    chk("inj_bits_2", {16'd0, inj_bit_count}, 32'd2);
`endif

    // Drop en while stalled
    out_ready = 1'b0; en = 1'b0;
    repeat (2) cyc("drophold");
    out_ready = 1'b1;
    cyc("dropacc");
    chk("drop_idle", {31'd0, busy}, 32'd0);
    seed = 7'(($urandom_range(1, 127)));
    en = 1'b1;
    cyc("restart");
    cyc("run");

    // Reset mid-run with valid high
    rst_n = 1'b0;
    cyc("midrst");
    rst_n = 1'b1;

    // Counter wrap: 17 accepts with CNT_W=4
    seed = 7'h7F; en = 1'b1; out_ready = 1'b1;
    cyc("wrapst");
    repeat (17) cyc("wrap");
    chk("wrap_count", {28'd0, word_count}, 32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst_n     = ($urandom_range(0, 99) != 0);
      en        = ($urandom_range(0, 9) < 8);
      out_ready = ($urandom_range(0, 9) < 6);
      inj_req   = ($urandom_range(0, 9) == 0);
      inj_mask  = 8'($urandom);
      seed      = 7'($urandom);
      cyc("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
